// File: rtl/multi_cycle_control_unit.sv
// Moore sequencer for the multi-cycle RV32I core: IF/ID/EX/MEM/WB/NEXTPC/HALT.
// Define MEM_HANDSHAKE_EN to make IF and MEM wait on mem_ready.
module multi_cycle_control_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic                   alu_bcond,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_source,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic                   mem_to_reg,
  output logic                   pc_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   halted,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_NEXTPC = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t state_q;
  state_t next_state;
  logic   retire;
  logic   mem_ok;

`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif

  assign state = state_q;

  always_comb begin
    next_state = state_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        ir_write  = mem_ok;
        alu_src_b = 2'd1;
        if (mem_ok) next_state = S_ID;
      end
      S_ID: begin
        alu_src_b = 2'd2;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: next_state = S_EX;
          OP_ECALL: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
          default: next_state = S_NEXTPC;
        endcase
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'd2;
            next_state = S_WB;
          end
          OP_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            alu_op     = 2'd2;
            next_state = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            next_state = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
            if (alu_bcond) begin
              pc_write   = 1'b1;
              pc_source  = 1'b1;
              next_state = S_IF;
              retire     = 1'b1;
            end else begin
              next_state = S_NEXTPC;
            end
          end
          // Link value PC+4 comes straight off the ALU while ALUOut still holds the target.
          OP_JAL: begin
            alu_src_b  = 2'd1;
            reg_write  = 1'b1;
            pc_to_reg  = 1'b1;
            pc_write   = 1'b1;
            pc_source  = 1'b1;
            next_state = S_IF;
            retire     = 1'b1;
          end
          OP_JALR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'd2;
            next_state = S_WB;
          end
          default: next_state = S_NEXTPC;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = mem_ok;
          if (mem_ok) begin
            next_state = S_IF;
            retire     = 1'b1;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ok) next_state = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        alu_src_b  = 2'd1;
        pc_write   = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        pc_to_reg  = (opcode == OP_JALR);
        pc_source  = (opcode == OP_JALR);
        next_state = S_IF;
        retire     = 1'b1;
      end
      S_NEXTPC: begin
        alu_src_b  = 2'd1;
        pc_write   = 1'b1;
        next_state = S_IF;
        retire     = 1'b1;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IF;
    endcase
    // Reset must not let a stale state write the PC, IR, registers or memory.
    if (reset) begin
      pc_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IF;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= next_state;
      if (retire) instr_count <= instr_count + 1'b1;
      if (next_state == S_HALT) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Scoreboard bench for multi_cycle_control_unit: per-instruction cycle model feeds a queue
// that a negedge monitor drains against the DUT outputs.
module tb_multi_cycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        alu_bcond;
  logic        mem_ready;
  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_write, mem_to_reg, pc_to_reg, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .halted(halted), .state(state), .instr_count(instr_count)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw, pcs, iod, mr, mw, irw, rw, m2r, p2r, a;
    logic [1:0]  b, op;
    logic        hlt;
    logic [31:0] cnt;
    logic        msk;
  } exp_t;

  localparam logic [6:0] OPC [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000,
                                       7'b1110011};
  localparam logic [6:0] NOPS [0:3] = '{7'b0000000, 7'b0110111, 7'b0010111, 7'b0001111};

  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned model_count;
  logic        model_halted;

  function automatic exp_t mk(input logic [2:0] st, input logic a, input logic [1:0] b,
                              input logic [1:0] op);
    exp_t e;
    e = '0;
    e.st = st;
    e.a = a;
    e.b = b;
    e.op = op;
    return e;
  endfunction

  task automatic cycle(input exp_t e, input logic [6:0] opc, input logic bc, input logic rdy,
                       input logic rst);
    opcode = opc;
    alu_bcond = bc;
    mem_ready = rdy;
    reset = rst;
    e.hlt = model_halted;
    e.cnt = model_count;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic resetCycle(input logic [2:0] st);
    exp_t e;
    e = mk(st, 1'b0, 2'd0, 2'd0);
    e.msk = 1'b1;
    cycle(e, 7'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    model_count = 0;
    model_halted = 1'b0;
  endtask

  function automatic int waitCycles();
`ifdef MEM_HANDSHAKE_EN
    return $urandom_range(0, 3);
`else
    return 0;
`endif
  endfunction

  function automatic logic readyBit();
`ifdef MEM_HANDSHAKE_EN
    return 1'b1;
`else
    return 1'($urandom);
`endif
  endfunction

  // Memory stage of a load or store, stretched by wait cycles when handshaking.
  task automatic memStage(input logic [6:0] opc, input logic store);
    exp_t e;
    int waits;
    waits = waitCycles();
    e = mk(3'd3, 1'b0, store ? 2'd1 : 2'd0, 2'd0);
    e.iod = 1'b1;
    e.mr = !store;
    e.mw = store;
    for (int i = 0; i < waits; i++) cycle(e, opc, 1'($urandom), 1'b0, 1'b0);
    e.pcw = store;
    cycle(e, opc, 1'($urandom), readyBit(), 1'b0);
  endtask

  task automatic writeBack(input logic [6:0] opc, input logic m2r, input logic p2r);
    exp_t e;
    e = mk(3'd4, 1'b0, 2'd1, 2'd0);
    e.rw = 1'b1;
    e.pcw = 1'b1;
    e.m2r = m2r;
    e.p2r = p2r;
    e.pcs = p2r;
    cycle(e, opc, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic nextPc(input logic [6:0] opc);
    exp_t e;
    e = mk(3'd5, 1'b0, 2'd1, 2'd0);
    e.pcw = 1'b1;
    cycle(e, opc, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // One whole instruction: kinds 0..8 = R, I, LW, SW, BR, JAL, JALR, NOP, ECALL.
  task automatic applyStimulus(input int kind, input logic bc);
    exp_t e;
    logic [6:0] opc;
    int waits;
    opc = (kind == 7) ? NOPS[$urandom_range(0, 3)] : OPC[kind];
    waits = waitCycles();
    e = mk(3'd0, 1'b0, 2'd1, 2'd0);
    e.mr = 1'b1;
    for (int i = 0; i < waits; i++) cycle(e, 7'($urandom), 1'($urandom), 1'b0, 1'b0);
    e.irw = 1'b1;
    cycle(e, 7'($urandom), 1'($urandom), readyBit(), 1'b0);
    cycle(mk(3'd1, 1'b0, 2'd2, 2'd0), opc, 1'($urandom), 1'($urandom), 1'b0);
    case (kind)
      0: begin
        cycle(mk(3'd2, 1'b1, 2'd0, 2'd2), opc, 1'($urandom), 1'($urandom), 1'b0);
        writeBack(opc, 1'b0, 1'b0);
      end
      1: begin
        cycle(mk(3'd2, 1'b1, 2'd2, 2'd2), opc, 1'($urandom), 1'($urandom), 1'b0);
        writeBack(opc, 1'b0, 1'b0);
      end
      2: begin
        cycle(mk(3'd2, 1'b1, 2'd2, 2'd0), opc, 1'($urandom), 1'($urandom), 1'b0);
        memStage(opc, 1'b0);
        writeBack(opc, 1'b1, 1'b0);
      end
      3: begin
        cycle(mk(3'd2, 1'b1, 2'd2, 2'd0), opc, 1'($urandom), 1'($urandom), 1'b0);
        memStage(opc, 1'b1);
      end
      4: begin
        e = mk(3'd2, 1'b1, 2'd0, 2'd1);
        e.pcw = bc;
        e.pcs = bc;
        cycle(e, opc, bc, 1'($urandom), 1'b0);
        if (!bc) nextPc(opc);
      end
      5: begin
        e = mk(3'd2, 1'b0, 2'd1, 2'd0);
        e.rw = 1'b1;
        e.p2r = 1'b1;
        e.pcw = 1'b1;
        e.pcs = 1'b1;
        cycle(e, opc, 1'($urandom), 1'($urandom), 1'b0);
      end
      6: begin
        cycle(mk(3'd2, 1'b1, 2'd2, 2'd0), opc, 1'($urandom), 1'($urandom), 1'b0);
        writeBack(opc, 1'b0, 1'b1);
      end
      7: nextPc(opc);
      default: begin
        model_halted = 1'b1;
        model_count = model_count + 1;
        for (int i = 0; i < 20; i++)
          cycle(mk(3'd6, 1'b0, 2'd0, 2'd0), 7'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        resetCycle(3'd6);
      end
    endcase
    if (kind != 8) model_count = model_count + 1;
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t a;
    a = {state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
         mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op, halted, instr_count, e.msk};
    if (e.msk) begin
      {a.pcs, a.iod, a.m2r, a.p2r, a.a, a.b, a.op} = '0;
      {e.pcs, e.iod, e.m2r, e.p2r, e.a, e.b, e.op} = '0;
    end
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL cycle_outputs state=%0d actual=%h required=%h (st,pcw,pcs,iod,mr,mw,irw,rw,m2r,p2r,a,b,op,hlt,cnt,msk)",
               e.st, a, e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int r;
    reset = 1'b1;
    opcode = 7'd0;
    alu_bcond = 1'b0;
    mem_ready = 1'b0;
    model_count = 0;
    model_halted = 1'b0;
    @(posedge clk);
    #1;
    resetCycle(3'd0);
    applyStimulus(0, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(3, 1'b0);
    applyStimulus(4, 1'b1);
    applyStimulus(4, 1'b0);
    applyStimulus(5, 1'b0);
    applyStimulus(6, 1'b0);
    applyStimulus(7, 1'b0);
    resetCycle(3'd0);
    applyStimulus(1, 1'b0);
    applyStimulus(8, 1'b0);
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 39);
      if (r == 0) applyStimulus(8, 1'b0);
      else if (r == 1) resetCycle(3'd0);
      else applyStimulus(r % 8, 1'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
